// File: rtl/uart_rx_fifo.sv
// uart_rx_fifo: oversampled serial receiver with majority-vote bit sampling,
// false-start rejection, framing/parity checks and a small output FIFO with
// a valid/ready handshake and a sticky overrun flag.
module uart_rx_fifo #(
    parameter int CLK_HZ     = 10_000_000,
    parameter int BAUD       = 31250,
    parameter int DATA_BITS  = 8,
    parameter int PARITY     = 0,
    parameter int STOP_BITS  = 1,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                 clk_i,
    input  logic                 nrst_i,
    input  logic                 rxData_i,
    output logic [DATA_BITS-1:0] data_o,
    output logic                 valid_o,
    input  logic                 ready_i,
    output logic                 frameErr_o,
    output logic                 parityErr_o,
    output logic                 overrun_o,
    input  logic                 clrErr_i,
    output logic                 busy_o
);

    // Clock cycles per bit; must be at least 16 for the mid-bit vote window.
    localparam int CPB = CLK_HZ / BAUD;
    localparam int CW  = $clog2(CPB);
    localparam int AW  = $clog2(FIFO_DEPTH);
    localparam int BW  = $clog2(DATA_BITS);

    localparam logic [CW-1:0] CNT_LAST = CW'(CPB - 1);
    localparam logic [CW-1:0] SAMP_A   = CW'(CPB / 2 - 1);
    localparam logic [CW-1:0] SAMP_B   = CW'(CPB / 2);
    localparam logic [CW-1:0] SAMP_C   = CW'(CPB / 2 + 1);
    localparam logic [BW-1:0] BIT_LAST = BW'(DATA_BITS - 1);
    localparam logic [AW:0]   CNT_FULL = (AW + 1)'(FIFO_DEPTH);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_PARITY,
        S_STOP,
        S_BREAK
    } state_t;

    state_t               state;
    logic                 sync1;
    logic                 rxs;
    logic [CW-1:0]        cnt;
    logic [BW-1:0]        bit_idx;
    logic                 stop_idx;
    logic                 stop_low;
    logic                 samp_a;
    logic                 samp_b;
    logic [DATA_BITS-1:0] shreg;
    logic                 par_bit;

    logic                 vote;
    logic                 vote_now;
    logic                 cnt_end;
    logic                 last_stop;
    logic                 par_err;
    logic                 push_req;

    logic [DATA_BITS-1:0] mem [FIFO_DEPTH];
    logic [AW-1:0]        wr_ptr;
    logic [AW-1:0]        rd_ptr;
    logic [AW:0]          count;
    logic                 full;
    logic                 pop;
    logic                 do_push;
    logic                 overrun_set;

    // Two-flop synchroniser for the asynchronous line; idles high out of reset.
    always_ff @(posedge clk_i or negedge nrst_i) begin
        // NOTE: sequential state uses non-blocking assignments so every flop
        // samples the values present before the clock edge.
        if (!nrst_i) begin
            sync1 <= 1'b1;
            rxs   <= 1'b1;
        end else begin
            sync1 <= rxData_i;
            rxs   <= sync1;
        end
    end

    // Capture the first two of the three mid-bit samples; the third is live rxs.
    always_ff @(posedge clk_i or negedge nrst_i) begin
        if (!nrst_i) begin
            samp_a <= 1'b1;
            samp_b <= 1'b1;
        end else begin
            if (cnt == SAMP_A) samp_a <= rxs;
            if (cnt == SAMP_B) samp_b <= rxs;
        end
    end

    // Vote, parity check and push decision, all valid in the vote cycle.
    always_comb begin
        // NOTE: each always_comb output gets a default first so no latch is inferred.
        vote      = (samp_a & samp_b) | (samp_a & rxs) | (samp_b & rxs);
        vote_now  = (cnt == SAMP_C);
        cnt_end   = (cnt == CNT_LAST);
        last_stop = (STOP_BITS == 1) || stop_idx;
        par_err   = 1'b0;
        if (PARITY == 1) par_err = (^shreg) ^ par_bit;
        else if (PARITY == 2) par_err = ~((^shreg) ^ par_bit);
        push_req  = (state == S_STOP) && vote_now && last_stop &&
                    vote && !stop_low && !par_err;
    end

    // Receive FSM with registered error pulses and busy flag.
    always_ff @(posedge clk_i or negedge nrst_i) begin
        if (!nrst_i) begin
            state       <= S_IDLE;
            cnt         <= '0;
            bit_idx     <= '0;
            stop_idx    <= 1'b0;
            stop_low    <= 1'b0;
            shreg       <= '0;
            par_bit     <= 1'b0;
            frameErr_o  <= 1'b0;
            parityErr_o <= 1'b0;
            busy_o      <= 1'b0;
        end else begin
            frameErr_o  <= 1'b0;
            parityErr_o <= 1'b0;
            cnt         <= cnt_end ? '0 : cnt + 1'b1;
            case (state)
                S_IDLE: begin
                    cnt <= '0;
                    if (!rxs) begin
                        state  <= S_START;
                        busy_o <= 1'b1;
                    end
                end
                S_START: begin
                    if (vote_now && vote) begin
                        // Line bounced back high: a glitch, not a start bit.
                        state  <= S_IDLE;
                        busy_o <= 1'b0;
                        cnt    <= '0;
                    end else if (cnt_end) begin
                        state   <= S_DATA;
                        bit_idx <= '0;
                    end
                end
                S_DATA: begin
                    if (vote_now) shreg <= {vote, shreg[DATA_BITS-1:1]};
                    if (cnt_end) begin
                        if (bit_idx == BIT_LAST) begin
                            state    <= (PARITY != 0) ? S_PARITY : S_STOP;
                            stop_idx <= 1'b0;
                            stop_low <= 1'b0;
                        end else begin
                            bit_idx <= bit_idx + 1'b1;
                        end
                    end
                end
                S_PARITY: begin
                    if (vote_now) par_bit <= vote;
                    if (cnt_end) begin
                        state    <= S_STOP;
                        stop_idx <= 1'b0;
                        stop_low <= 1'b0;
                    end
                end
                S_STOP: begin
                    if (vote_now && last_stop) begin
                        // Decide at the final stop vote so the next start edge
                        // is caught even on back-to-back frames.
                        cnt <= '0;
                        if (!vote || stop_low) begin
                            frameErr_o <= 1'b1;
                            state      <= S_BREAK;
                        end else begin
                            parityErr_o <= par_err;
                            state       <= S_IDLE;
                            busy_o      <= 1'b0;
                        end
                    end else begin
                        if (vote_now) stop_low <= ~vote;
                        if (cnt_end) stop_idx <= 1'b1;
                    end
                end
                S_BREAK: begin
                    // Wait out a held-low line so it reports only one error.
                    cnt <= '0;
                    if (rxs) begin
                        state  <= S_IDLE;
                        busy_o <= 1'b0;
                    end
                end
                default: begin
                    state  <= S_IDLE;
                    busy_o <= 1'b0;
                    cnt    <= '0;
                end
            endcase
        end
    end

    assign pop         = valid_o & ready_i;
    assign full        = (count == CNT_FULL);
    assign do_push     = push_req & (~full | pop);
    assign overrun_set = push_req & full & ~pop;
    assign valid_o     = (count != '0);
    assign data_o      = valid_o ? mem[rd_ptr] : '0;

    // FIFO storage; written on accepted pushes only.
    always_ff @(posedge clk_i) begin
        // NOTE: the storage array has no reset; emptiness is tracked by count
        // and data_o is forced to zero while the FIFO is empty.
        if (do_push) mem[wr_ptr] <= shreg;
    end

    // FIFO pointers and occupancy; pointers wrap naturally at the power-of-two depth.
    always_ff @(posedge clk_i or negedge nrst_i) begin
        if (!nrst_i) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)     rd_ptr <= rd_ptr + 1'b1;
            case ({do_push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // Sticky overrun flag; a new overrun wins over a simultaneous clear.
    always_ff @(posedge clk_i or negedge nrst_i) begin
        if (!nrst_i)          overrun_o <= 1'b0;
        else if (overrun_set) overrun_o <= 1'b1;
        else if (clrErr_i)    overrun_o <= 1'b0;
    end

endmodule

// File: tb/tb_uart_rx_fifo.sv
// tb_uart_rx_fifo: directed bench for uart_rx_fifo. A default 8N1 instance
// covers timing, glitch, break, overrun and reset; an odd-parity instance
// covers the parity check.
module tb_uart_rx_fifo;

    localparam int CPB = 10_000_000 / 31250;  // 320 cycles per bit
    // First valid_o cycle after the start edge: 2 sync flops + 1 idle detect,
    // 9 full bit periods (start + 8 data), vote at CPB/2+1, then the push edge.
    localparam int LAT = 3 + 9 * CPB + CPB / 2 + 2;

    logic       clk = 1'b0;
    logic       nrst = 1'b0;
    logic       rx = 1'b1;
    logic       rx_p = 1'b1;
    logic       ready = 1'b0;
    logic       ready_p = 1'b1;
    logic       clr = 1'b0;

    logic [7:0] data_o, data_p;
    logic       valid_o, valid_p;
    logic       ferr, ferr_p, perr, perr_p, ovr, ovr_p, busy, busy_p;

    int n_vec = 0;
    int n_err = 0;

    always #50 clk = ~clk;

    uart_rx_fifo u_dut (
        .clk_i(clk), .nrst_i(nrst), .rxData_i(rx),
        .data_o(data_o), .valid_o(valid_o), .ready_i(ready),
        .frameErr_o(ferr), .parityErr_o(perr), .overrun_o(ovr),
        .clrErr_i(clr), .busy_o(busy)
    );

    uart_rx_fifo #(.PARITY(2)) u_dut_par (
        .clk_i(clk), .nrst_i(nrst), .rxData_i(rx_p),
        .data_o(data_p), .valid_o(valid_p), .ready_i(ready_p),
        .frameErr_o(ferr_p), .parityErr_o(perr_p), .overrun_o(ovr_p),
        .clrErr_i(clr), .busy_o(busy_p)
    );

    // Monitor state: monotonic counters and pop logs, sampled on the falling edge.
    int         cyc = 0;
    int         pop_n = 0, pop_np = 0;
    int         valid_hi = 0, ferr_n = 0, perr_n = 0, ferr_np = 0, perr_np = 0;
    int         rise_cyc = 0;
    logic       valid_prev = 1'b0;
    logic [7:0] pop_log  [64];
    logic [7:0] pop_logp [64];

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (valid_o && ready) begin
            pop_log[pop_n] <= data_o;
            pop_n          <= pop_n + 1;
        end
        if (valid_p && ready_p) begin
            pop_logp[pop_np] <= data_p;
            pop_np           <= pop_np + 1;
        end
        if (valid_o) valid_hi <= valid_hi + 1;
        if (valid_o && !valid_prev) rise_cyc <= cyc;
        valid_prev <= valid_o;
        if (ferr)   ferr_n  <= ferr_n + 1;
        if (perr)   perr_n  <= perr_n + 1;
        if (ferr_p) ferr_np <= ferr_np + 1;
        if (perr_p) perr_np <= perr_np + 1;
    end

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic bit_time(input bit sel, input bit val);
        if (sel) rx_p = val;
        else     rx   = val;
        idle(CPB);
    endtask

    // Drives one frame LSB first; the stop-bit level is left on the line.
    task automatic send_frame(input bit sel, input logic [7:0] d,
                              input bit with_par, input bit par, input bit stop);
        bit_time(sel, 1'b0);
        for (int i = 0; i < 8; i++) bit_time(sel, d[i]);
        if (with_par) bit_time(sel, par);
        bit_time(sel, stop);
    endtask

    task automatic test_reset();
        nrst = 1'b0;
        idle(5);
        n_vec++; if (data_o !== 8'h00) begin n_err++; $display("FAIL reset_data: got %h want %h", data_o, 8'h00); end
        n_vec++; if (valid_o !== 1'b0) begin n_err++; $display("FAIL reset_valid: got %b want 0", valid_o); end
        n_vec++; if (ferr !== 1'b0)    begin n_err++; $display("FAIL reset_ferr: got %b want 0", ferr); end
        n_vec++; if (perr !== 1'b0)    begin n_err++; $display("FAIL reset_perr: got %b want 0", perr); end
        n_vec++; if (ovr !== 1'b0)     begin n_err++; $display("FAIL reset_ovr: got %b want 0", ovr); end
        n_vec++; if (busy !== 1'b0)    begin n_err++; $display("FAIL reset_busy: got %b want 0", busy); end
        nrst = 1'b1;
        idle(5);
        n_vec++; if (busy !== 1'b0)    begin n_err++; $display("FAIL release_busy: got %b want 0", busy); end
    endtask

    task automatic test_basic();
        int p0, v0, f0, e0, t0;
        ready = 1'b1;
        p0 = pop_n; v0 = valid_hi; f0 = ferr_n; e0 = perr_n; t0 = cyc;
        send_frame(1'b0, 8'h90, 1'b0, 1'b0, 1'b1);
        idle(CPB);
        n_vec++; if (pop_n - p0 !== 1)      begin n_err++; $display("FAIL basic_pops: got %0d want 1", pop_n - p0); end
        n_vec++; if (pop_log[p0] !== 8'h90) begin n_err++; $display("FAIL basic_data: got %h want 90", pop_log[p0]); end
        n_vec++; if (valid_hi - v0 !== 1)   begin n_err++; $display("FAIL basic_valid_len: got %0d want 1", valid_hi - v0); end
        n_vec++; if (rise_cyc - t0 !== LAT) begin n_err++; $display("FAIL basic_latency: got %0d want %0d", rise_cyc - t0, LAT); end
        n_vec++; if (ferr_n - f0 !== 0)     begin n_err++; $display("FAIL basic_ferr: got %0d want 0", ferr_n - f0); end
        n_vec++; if (perr_n - e0 !== 0)     begin n_err++; $display("FAIL basic_perr: got %0d want 0", perr_n - e0); end
    endtask

    task automatic test_glitch();
        int p0, v0, f0, e0;
        p0 = pop_n; v0 = valid_hi; f0 = ferr_n; e0 = perr_n;
        rx = 1'b0;
        idle(40);
        n_vec++; if (busy !== 1'b1) begin n_err++; $display("FAIL glitch_busy_start: got %b want 1", busy); end
        idle(10);
        rx = 1'b1;
        idle(300);
        n_vec++; if (busy !== 1'b0)         begin n_err++; $display("FAIL glitch_busy_idle: got %b want 0", busy); end
        n_vec++; if (valid_hi - v0 !== 0)   begin n_err++; $display("FAIL glitch_valid: got %0d want 0", valid_hi - v0); end
        n_vec++; if ((ferr_n - f0) + (perr_n - e0) !== 0) begin n_err++; $display("FAIL glitch_errs: got %0d want 0", (ferr_n - f0) + (perr_n - e0)); end
        send_frame(1'b0, 8'h3C, 1'b0, 1'b0, 1'b1);
        idle(CPB);
        n_vec++; if (pop_n - p0 !== 1)      begin n_err++; $display("FAIL glitch_pops: got %0d want 1", pop_n - p0); end
        n_vec++; if (pop_log[p0] !== 8'h3C) begin n_err++; $display("FAIL glitch_data: got %h want 3c", pop_log[p0]); end
    endtask

    task automatic test_break();
        int p0, v0, f0;
        p0 = pop_n; v0 = valid_hi; f0 = ferr_n;
        send_frame(1'b0, 8'h45, 1'b0, 1'b0, 1'b0);
        idle(2000);
        n_vec++; if (busy !== 1'b1)       begin n_err++; $display("FAIL break_busy: got %b want 1", busy); end
        n_vec++; if (ferr_n - f0 !== 1)   begin n_err++; $display("FAIL break_ferr_count: got %0d want 1", ferr_n - f0); end
        n_vec++; if (valid_hi - v0 !== 0) begin n_err++; $display("FAIL break_valid: got %0d want 0", valid_hi - v0); end
        rx = 1'b1;
        idle(10);
        n_vec++; if (busy !== 1'b0)       begin n_err++; $display("FAIL break_exit: got %b want 0", busy); end
        send_frame(1'b0, 8'h7F, 1'b0, 1'b0, 1'b1);
        idle(CPB);
        n_vec++; if (pop_n - p0 !== 1)      begin n_err++; $display("FAIL break_pops: got %0d want 1", pop_n - p0); end
        n_vec++; if (pop_log[p0] !== 8'h7F) begin n_err++; $display("FAIL break_data: got %h want 7f", pop_log[p0]); end
        n_vec++; if (ferr_n - f0 !== 1)     begin n_err++; $display("FAIL break_ferr_after: got %0d want 1", ferr_n - f0); end
    endtask

    task automatic test_overrun();
        int         p0;
        logic [7:0] exp;
        ready = 1'b0;
        p0 = pop_n;
        for (int i = 1; i <= 4; i++) send_frame(1'b0, 8'(i), 1'b0, 1'b0, 1'b1);
        n_vec++; if (ovr !== 1'b0)       begin n_err++; $display("FAIL ovr_at_full: got %b want 0", ovr); end
        n_vec++; if (valid_o !== 1'b1)   begin n_err++; $display("FAIL ovr_valid: got %b want 1", valid_o); end
        send_frame(1'b0, 8'h05, 1'b0, 1'b0, 1'b1);
        n_vec++; if (ovr !== 1'b1)       begin n_err++; $display("FAIL ovr_set: got %b want 1", ovr); end
        n_vec++; if (data_o !== 8'h01)   begin n_err++; $display("FAIL ovr_head_hold: got %h want 01", data_o); end
        ready = 1'b1;
        idle(8);
        n_vec++; if (pop_n - p0 !== 4)   begin n_err++; $display("FAIL ovr_pops: got %0d want 4", pop_n - p0); end
        for (int i = 0; i < 4; i++) begin
            exp = 8'(i + 1);
            n_vec++; if (pop_log[p0 + i] !== exp) begin n_err++; $display("FAIL ovr_order%0d: got %h want %h", i, pop_log[p0 + i], exp); end
        end
        n_vec++; if (valid_o !== 1'b0)   begin n_err++; $display("FAIL ovr_drained: got %b want 0", valid_o); end
        n_vec++; if (ovr !== 1'b1)       begin n_err++; $display("FAIL ovr_sticky: got %b want 1", ovr); end
        clr = 1'b1;
        idle(1);
        clr = 1'b0;
        n_vec++; if (ovr !== 1'b0)       begin n_err++; $display("FAIL ovr_clear: got %b want 0", ovr); end
    endtask

    // 0xA5 has four ones, so odd parity requires the parity bit to be 1;
    // sending 0 is the bad frame, sending 1 is the good one.
    task automatic test_parity();
        int p0, e0, f0;
        p0 = pop_np; e0 = perr_np; f0 = ferr_np;
        send_frame(1'b1, 8'hA5, 1'b1, 1'b0, 1'b1);
        idle(CPB);
        n_vec++; if (perr_np - e0 !== 1) begin n_err++; $display("FAIL par_bad_perr: got %0d want 1", perr_np - e0); end
        n_vec++; if (pop_np - p0 !== 0)  begin n_err++; $display("FAIL par_bad_pops: got %0d want 0", pop_np - p0); end
        send_frame(1'b1, 8'hA5, 1'b1, 1'b1, 1'b1);
        idle(CPB);
        n_vec++; if (pop_np - p0 !== 1)      begin n_err++; $display("FAIL par_good_pops: got %0d want 1", pop_np - p0); end
        n_vec++; if (pop_logp[p0] !== 8'hA5) begin n_err++; $display("FAIL par_good_data: got %h want a5", pop_logp[p0]); end
        n_vec++; if (perr_np - e0 !== 1)     begin n_err++; $display("FAIL par_good_perr: got %0d want 1", perr_np - e0); end
        n_vec++; if (ferr_np - f0 !== 0)     begin n_err++; $display("FAIL par_ferr: got %0d want 0", ferr_np - f0); end
    endtask

    task automatic test_reset_mid_frame();
        int         p0, f0, e0;
        logic [7:0] d;
        ready = 1'b0;
        send_frame(1'b0, 8'h55, 1'b0, 1'b0, 1'b1);
        idle(10);
        n_vec++; if (valid_o !== 1'b1) begin n_err++; $display("FAIL mid_preload: got %b want 1", valid_o); end
        d = 8'hE6;
        bit_time(1'b0, 1'b0);
        for (int i = 0; i < 4; i++) bit_time(1'b0, d[i]);
        rx = d[4];
        idle(CPB / 2);
        n_vec++; if (busy !== 1'b1)    begin n_err++; $display("FAIL mid_busy: got %b want 1", busy); end
        nrst = 1'b0;
        idle(3);
        n_vec++; if (data_o !== 8'h00) begin n_err++; $display("FAIL mid_data: got %h want 00", data_o); end
        n_vec++; if (valid_o !== 1'b0) begin n_err++; $display("FAIL mid_valid: got %b want 0", valid_o); end
        n_vec++; if (busy !== 1'b0)    begin n_err++; $display("FAIL mid_busy_rst: got %b want 0", busy); end
        n_vec++; if ({ferr, perr, ovr} !== 3'b000) begin n_err++; $display("FAIL mid_flags: got %b want 000", {ferr, perr, ovr}); end
        rx = 1'b1;
        idle(2);
        nrst = 1'b1;
        f0 = ferr_n; e0 = perr_n;
        idle(2 * CPB);
        n_vec++; if ((ferr_n - f0) + (perr_n - e0) !== 0) begin n_err++; $display("FAIL mid_no_err: got %0d want 0", (ferr_n - f0) + (perr_n - e0)); end
        n_vec++; if (valid_o !== 1'b0) begin n_err++; $display("FAIL mid_empty: got %b want 0", valid_o); end
        ready = 1'b1;
        p0 = pop_n;
        send_frame(1'b0, 8'h12, 1'b0, 1'b0, 1'b1);
        idle(CPB);
        n_vec++; if (pop_n - p0 !== 1)      begin n_err++; $display("FAIL mid_pops: got %0d want 1", pop_n - p0); end
        n_vec++; if (pop_log[p0] !== 8'h12) begin n_err++; $display("FAIL mid_next_data: got %h want 12", pop_log[p0]); end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_glitch();
        test_break();
        test_overrun();
        test_parity();
        test_reset_mid_frame();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    // Hard stop in case the sequence above stalls.
    initial begin
        #(100 * 90_000);
        $display("FAIL watchdog: got timeout want completion");
        $fatal(1);
    end

endmodule
